// File: rtl/img_pkg.sv
// Shared image-pipeline constants and pixel types (also used by the Sobel stage).
package img_pkg;

    // Frame geometry
    localparam int unsigned IMG_WIDTH  = 720;
    localparam int unsigned IMG_HEIGHT = 720;

    // BT.601-style luma weights scaled to 256, plus rounding offset
    localparam int unsigned COEF_R = 77;
    localparam int unsigned COEF_G = 150;
    localparam int unsigned COEF_B = 29;
    localparam int unsigned ROUND  = 128;

    // Arithmetic widths: 8-bit channel times each weight, and the rounded sum
    localparam int unsigned PR_W  = 15;
    localparam int unsigned PG_W  = 16;
    localparam int unsigned PB_W  = 13;
    localparam int unsigned SUM_W = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [7:0] gray_t;

endpackage

// File: rtl/rgb_to_gray_if.sv
// FIFO-side signals of the grayscale stage: RGB FWFT input, gray output, frame flag.
interface rgb_to_gray_if;
    import img_pkg::*;

    logic  in_rd_en;
    logic  in_empty;
    rgb_t  in_dout;
    logic  out_wr_en;
    logic  out_full;
    gray_t out_din;
    logic  frame_done;

    // Converter side
    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din,
        output frame_done
    );

    // FIFO / environment side
    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din,
        input  frame_done
    );

endinterface

// File: rtl/pixel_position_counter.sv
// Column/row tracker for a raster stream; pulses frame_done_o after the last pixel.
module pixel_position_counter
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT,
    localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             frame_done_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             frame_done_q, frame_done_d;
    logic             col_last_c;
    logic             row_last_c;

    assign col_last_c = (col_q == COL_W'(WIDTH - 1));
    assign row_last_c = (row_q == ROW_W'(HEIGHT - 1));

    // Next position: step column, carry into row on wrap, flag the frame's last pixel
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (inc_i) begin
            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            frame_done_d = col_last_c && row_last_c;
        end
    end

    // Position and frame flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/rgb_to_gray.sv
// RGB-to-luma stage: two-deep registered pipeline between an RGB FWFT FIFO and the gray FIFO.
module rgb_to_gray
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned HEIGHT = IMG_HEIGHT
) (
    input  logic          clk,
    input  logic          rst,
    rgb_to_gray_if.master bus
);

    localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic              s1_valid_q;
    logic [PR_W-1:0]   pr_q;
    logic [PG_W-1:0]   pg_q;
    logic [PB_W-1:0]   pb_q;
    logic              s2_valid_q;
    gray_t             gray_q;

    logic              advance_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic [PR_W-1:0]   pr_c;
    logic [PG_W-1:0]   pg_c;
    logic [PB_W-1:0]   pb_c;
    logic [SUM_W-1:0]  sum_c;
    gray_t             gray_d;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              frame_done;

    // Whole pipeline moves together unless a valid result is blocked by a full output FIFO.
    // Strobes are held low while reset is asserted.
    assign advance_c = !s2_valid_q || !bus.out_full;
    assign rd_en_c   = !rst && !bus.in_empty && advance_c;
    assign wr_en_c   = !rst && s2_valid_q && !bus.out_full;

    // Weighted channels; widths chosen so 255*coef never overflows
    always_comb begin
        pr_c = PR_W'(bus.in_dout.r) * PR_W'(COEF_R);
        pg_c = PG_W'(bus.in_dout.g) * PG_W'(COEF_G);
        pb_c = PB_W'(bus.in_dout.b) * PB_W'(COEF_B);
    end

    // Rounded sum; weights total 256 so the top bit is never set and bits [15:8] are the result
    always_comb begin
        sum_c  = SUM_W'(pr_q) + SUM_W'(pg_q) + SUM_W'(pb_q) + SUM_W'(ROUND);
        gray_d = gray_t'(sum_c >> 8);
    end

    // Stage 1 (products) and stage 2 (luma) registers, both gated by advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            pr_q       <= '0;
            pg_q       <= '0;
            pb_q       <= '0;
            s2_valid_q <= 1'b0;
            gray_q     <= '0;
        end else if (advance_c) begin
            s1_valid_q <= rd_en_c;
            pr_q       <= pr_c;
            pg_q       <= pg_c;
            pb_q       <= pb_c;
            s2_valid_q <= s1_valid_q;
            gray_q     <= gray_d;
        end
    end

    pixel_position_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .inc_i        (wr_en_c),
        .col_o        (col),
        .row_o        (row),
        .frame_done_o (frame_done)
    );

    // Position never leaves the frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (32'(col) < WIDTH && 32'(row) < HEIGHT)
                else $error("position out of frame");
        end
    end

    assign bus.in_rd_en   = rd_en_c;
    assign bus.out_wr_en  = wr_en_c;
    assign bus.out_din    = gray_q;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_rgb_to_gray.sv
// Scoreboard bench for rgb_to_gray: driver pushes expected luma on each pop, monitor checks each push.
module tb_rgb_to_gray;
    import img_pkg::*;

    localparam int W     = 720;
    localparam int H     = 4;
    localparam int FRAME = W * H;

    typedef struct {
        rgb_t  px;
        gray_t g;
        bit    lat;
    } src_t;

    typedef struct {
        gray_t g;
        int    cyc;
        bit    lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    rgb_to_gray_if bus ();

    rgb_to_gray #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    src_t src_q[$];
    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   drv_push = 0;
    logic last_rd  = 1'b0;
    int   mon_pos  = 0;
    bit   fd_exp   = 1'b0;
    int   fd_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic gray_t ref_gray(input rgb_t p);
        int unsigned s;
        s = 32'(p.r) * 77 + 32'(p.g) * 150 + 32'(p.b) * 29 + 128;
        return gray_t'(s >> 8);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle of the input/output FIFO model
    task automatic step(input bit hold_in, input bit full);
        @(negedge clk);
        bus.out_full = full;
        if (src_q.size() > 0 && !hold_in) begin
            bus.in_empty = 1'b0;
            bus.in_dout  = src_q[0].px;
        end else begin
            bus.in_empty = 1'b1;
            bus.in_dout  = 24'hDEAD00;
        end
        #1;
        last_rd = bus.in_rd_en;
        if (bus.out_wr_en) drv_push++;
        if (bus.in_rd_en) begin
            if (src_q.size() == 0) begin
                chk("pop_from_empty", 1, 0);
            end else begin
                exp_q.push_back('{src_q[0].g, cyc, src_q[0].lat});
                void'(src_q.pop_front());
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (src_q.size() > 0 || exp_q.size() > 0); i++) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        chk("drain_left", exp_q.size() + src_q.size(), 0);
    endtask

    // Monitor: compares every push and the frame_done pulse against the scoreboard
    always @(negedge clk) begin
        #1;
        if (rst) begin
            mon_pos = 0;
            fd_exp  = 1'b0;
            fd_cnt  = 0;
        end else begin
            exp_t e;
            if (bus.frame_done || fd_exp) chk("frame_done", bus.frame_done, fd_exp);
            if (bus.frame_done) fd_cnt++;
            fd_exp = 1'b0;
            if (bus.out_wr_en) begin
                chk("wr_while_full", bus.out_full, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_push", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gray", bus.out_din, e.g);
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                end
                fd_exp  = (mon_pos == FRAME - 1);
                mon_pos = (mon_pos == FRAME - 1) ? 0 : mon_pos + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] h;
        int         pops;
        bit         col_pending;
        bit         col_done;
        rgb_t       p;

        rst          = 1'b1;
        bus.in_empty = 1'b0;
        bus.in_dout  = 24'h123456;
        bus.out_full = 1'b0;

        // Reset state: strobes low even with data available
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", bus.in_rd_en, 0);
        chk("rst_wr_en", bus.out_wr_en, 0);
        chk("rst_out_din", bus.out_din, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_col", dut.u_pos.col_o, 0);
        chk("rst_row", dut.u_pos.row_o, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_empty = 1'b1;

        // Pure primaries, one at a time, fixed latency of 2
        src_q.push_back('{24'hFF0000, 8'd77, 1'b1});
        drain();
        src_q.push_back('{24'h00FF00, 8'd149, 1'b1});
        drain();
        src_q.push_back('{24'h0000FF, 8'd29, 1'b1});
        drain();

        // Back-to-back burst: three consecutive pops
        src_q.push_back('{24'h000000, 8'd0, 1'b1});
        src_q.push_back('{24'hFFFFFF, 8'd255, 1'b1});
        src_q.push_back('{24'h6496C8, 8'd141, 1'b1});
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            h[i] = last_rd;
        end
        chk("rd_burst", h, 4'b0111);
        drain();

        // Backpressure: equal-channel pixels map to themselves; only 2 pixels buffer while full
        for (int i = 0; i < 10; i++) begin
            src_q.push_back('{{8'(i * 20 + 7), 8'(i * 20 + 7), 8'(i * 20 + 7)}, 8'(i * 20 + 7), 1'b0});
        end
        pops = 0;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, (t >= 3 && t <= 8));
            pops += int'(last_rd);
            if (t == 8) chk("stall_pops", pops, 3);
        end
        drain();

        // Reset mid-stream with both stages full at col 357
        for (int i = 0; i < 400; i++) begin
            p = rgb_t'(24'($urandom()));
            src_q.push_back('{p, ref_gray(p), 1'b0});
        end
        for (int i = 0; i < 1000 && drv_push < 357; i++) step(1'b0, 1'b0);
        @(negedge clk);
        chk("col_before_rst", dut.u_pos.col_o, 357);
        chk("pipe_full_before_rst", {dut.s1_valid_q, dut.s2_valid_q}, 3);
        rst          = 1'b1;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        #1;
        chk("midrst_rd_en", bus.in_rd_en, 0);
        chk("midrst_wr_en", bus.out_wr_en, 0);
        chk("midrst_col", dut.u_pos.col_o, 0);
        chk("midrst_row", dut.u_pos.row_o, 0);
        chk("midrst_frame_done", bus.frame_done, 0);
        src_q.delete();
        exp_q.delete();
        drv_push = 0;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        bus.in_empty = 1'b1;

        // Two back-to-back frames of random pixels
        for (int i = 0; i < 2 * FRAME; i++) begin
            p = rgb_t'(24'($urandom()));
            src_q.push_back('{p, ref_gray(p), 1'b0});
        end
        col_pending = 1'b0;
        col_done    = 1'b0;
        for (int i = 0; i < 3 * FRAME && src_q.size() > 0; i++) begin
            step(1'b0, 1'b0);
            if (col_pending) begin
                chk("col_after_first_push", dut.u_pos.col_o, 1);
                col_pending = 1'b0;
            end
            if (drv_push == 1 && !col_done) begin
                col_pending = 1'b1;
                col_done    = 1'b1;
            end
        end
        drain();
        chk("frames_after_two", fd_cnt, 2);

        // Random empty/full toggling
        for (int i = 0; i < 5000; i++) begin
            p = rgb_t'(24'($urandom()));
            src_q.push_back('{p, ref_gray(p), 1'b0});
        end
        for (int i = 0; i < 40000 && src_q.size() > 0; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        drain();
        chk("frames_total", fd_cnt, (2 * FRAME + 5000) / FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_to_gray.md
Name: rgb_to_gray

Overview:
- Grayscale conversion stage directly upstream of the Sobel edge stage.
- Pops packed 24-bit RGB pixels from an input FIFO (first-word fall-through).
- Computes an 8-bit luma value through a 2-stage registered pipeline.
- Pushes the result into the 8-bit FIFO that feeds Sobel, and tracks pixel position to flag the end of each frame.

Parameters:
- WIDTH, 720, pixels per row
- HEIGHT, 720, rows per frame

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_rd_en  output  1  pop strobe to the RGB input FIFO
- in_empty  input  1  input FIFO empty
- in_dout  input  24  RGB pixel, valid while !in_empty: [23:16]=R, [15:8]=G, [7:0]=B
- out_wr_en  output  1  push strobe to the gray output FIFO
- out_full  input  1  output FIFO full
- out_din  output  8  gray pixel, valid when out_wr_en=1
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is pushed

Behaviour:
- Clock and reset: single clock domain. Reset rst, asynchronous, active-high; clock clk.
- Reset values: s1_valid=0, s2_valid=0, col=0, row=0, frame_done=0, out_din=0. Consequently in_rd_en=0 while in_empty=1, and out_wr_en=0.
- Pipeline control:
  - advance = !s2_valid || !out_full
  - in_rd_en = !in_empty && advance (combinational)
  - out_wr_en = s2_valid && !out_full (combinational)
- When advance=1, on the clock edge:
  - s2 takes s1's data and valid bit.
  - s1 captures the input products, with s1_valid = in_rd_en.
- When advance=0, both stages hold their values and no pop occurs.
- Bubbles (s1_valid=0) propagate normally. Data is never dropped or duplicated.
- Stage 1 registers three products:
  - pR = R*77 (15-bit)
  - pG = G*150 (16-bit)
  - pB = B*29 (13-bit)
- Stage 2 registers the result:
  - sum = pR+pG+pB+128, 17-bit unsigned
  - out_din = sum[15:8]
  - Coefficients total 256, so the maximum result is exactly 255 and saturation is never needed.
- Latency: a pixel popped on edge N is presented with out_wr_en at cycle N+2 when the output is not full. Throughput is 1 pixel/clk when unstalled.
- Position counters advance only on out_wr_en=1:
  - col increments, wrapping WIDTH-1 -> 0.
  - On that wrap, row increments, wrapping HEIGHT-1 -> 0.
- frame_done: registered. Asserted for exactly one cycle following the push with col=WIDTH-1 and row=HEIGHT-1. Counters are 0 in that cycle.
- Back-to-back frames: the next frame's first pixel may be pushed in the same cycle frame_done is high. No gap is required.
- Simultaneous in_empty=1 and out_full=0: the pipeline still advances, inserting a bubble and draining s2.
- out_full held high: at most 2 pixels are buffered internally, then in_rd_en=0.
- Reset mid-operation: in-flight pixels are discarded, counters clear, and no strobe is asserted during reset.
- All arithmetic is unsigned. There are no signed types.

Decomposition:
- Shared package img_pkg holds:
  - IMG_WIDTH=720 and IMG_HEIGHT=720, which are also used by Sobel
  - coefficient constants COEF_R=77, COEF_G=150, COEF_B=29, ROUND=128
  - the pixel typedefs rgb_t (24-bit packed struct r/g/b) and gray_t (8-bit)
- One natural sub-module: pixel_position_counter(WIDTH, HEIGHT).
  - Inputs: clk, rst, inc.
  - Outputs: col, row, frame_done.
  - Intended for reuse by Sobel's row/column tracking.

Test Plan:
- Single pixel 0xFF0000, then 0x00FF00, then 0x0000FF, no backpressure -> out_din 77, 149, 29, each 2 cycles after its pop.
- Pixels 0x000000, 0xFFFFFF, 0x6496C8 streamed back-to-back -> out_din 0, 255, 141 on consecutive cycles. in_rd_en stays high for 3 cycles.
- Stream 10 pixels with out_full held high for cycles 3-8:
  - in_rd_en drops after 2 buffered pixels.
  - On release, all 10 outputs appear in order with none lost or duplicated.
- Full WIDTH*HEIGHT frame of random RGB against a reference model -> every byte matches, and frame_done pulses exactly once, 1 cycle after the 518400th push. A second frame immediately follows with a correct second pulse.
- Assert rst while s1 and s2 are both valid and col=357 -> out_wr_en=0 during reset, counters read 0, and the first post-reset push is counted as col 0.
- Random in_empty/out_full toggling over 5000 pixels -> output sequence equals input order mapped through the formula, and out_wr_en is never high while out_full=1.
